// File: rtl/mux.sv
// mux: WIDTH-bit 2:1 selector for the cache read path.
// `out` is purely combinational for same-cycle hit data; `out_q`/`select_q`
// are an enable-loaded registered copy for pipelined consumers.
module mux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             select_q
);

  logic [WIDTH-1:0] out_d;
  logic             select_d;

  // Combinational select; the conditional operator gives X-merge in
  // simulation when select is unknown and a plain 2:1 mux in synthesis.
  always_comb begin
    out = select ? second : first;
  end

  // Next-state for the output register: load on en, otherwise hold.
  always_comb begin
    out_d    = out_q;
    select_d = select_q;
    if (en) begin
      out_d    = out;
      select_d = select;
    end
  end

  // Output register; synchronous reset wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      select_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      select_q <= select_d;
    end
  end

endmodule

// File: tb/tb_mux.sv
// tb_mux: scoreboard bench for mux at WIDTH = 1, 32 and 64.
// A driver applies stimulus and pushes the expected response into a queue;
// a monitor pops on each falling edge and compares all three instances.
module tb_mux;

  logic        clk;
  logic        rst, en, select;
  logic [63:0] first, second;

  logic [63:0] out64, q64;
  logic [31:0] out32, q32;
  logic        out1, q1;
  logic        sq64, sq32, sq1;

  mux #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst(rst), .first(first), .second(second), .select(select),
    .en(en), .out(out64), .out_q(q64), .select_q(sq64)
  );
  mux #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .first(first[31:0]), .second(second[31:0]),
    .select(select), .en(en), .out(out32), .out_q(q32), .select_q(sq32)
  );
  mux #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .first(first[0]), .second(second[0]),
    .select(select), .en(en), .out(out1), .out_q(q1), .select_q(sq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] e_out;
    logic [63:0] e_q;
    logic        e_sq;
    logic        chk_q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the register contents as a plain value plus the inputs
  // that were present at the previous driver step.
  logic [63:0] m_q;
  logic        m_sq;
  logic        m_valid;
  logic        p_rst, p_en, p_sel;
  logic [63:0] p_first, p_second;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out64", out64, e.e_out);
        check("out32", {32'h0, out32}, {32'h0, e.e_out[31:0]});
        check("out1", {63'h0, out1}, {63'h0, e.e_out[0]});
        if (e.chk_q) begin
          check("out_q64", q64, e.e_q);
          check("out_q32", {32'h0, q32}, {32'h0, e.e_q[31:0]});
          check("out_q1", {63'h0, q1}, {63'h0, e.e_q[0]});
          check("select_q64", {63'h0, sq64}, {63'h0, e.e_sq});
          check("select_q32", {63'h0, sq32}, {63'h0, e.e_sq});
          check("select_q1", {63'h0, sq1}, {63'h0, e.e_sq});
        end
      end
    end
  end

  // One cycle of stimulus: advance the model over the edge that samples the
  // previous inputs, then apply new inputs and record what must be seen.
  task automatic drive(input logic r, input logic e_n, input logic s,
                       input logic [63:0] f, input logic [63:0] sd);
    exp_t x;
    @(posedge clk);
    if (p_rst) begin
      m_q = 64'h0; m_sq = 1'b0; m_valid = 1'b1;
    end else if (p_en && m_valid) begin
      m_q  = p_sel ? p_second : p_first;
      m_sq = p_sel;
    end
    #1;
    rst = r; en = e_n; select = s; first = f; second = sd;
    p_rst = r; p_en = e_n; p_sel = s; p_first = f; p_second = sd;
    x.e_out = s ? sd : f;
    x.e_q   = m_q;
    x.e_sq  = m_sq;
    x.chk_q = m_valid;
    exp_q.push_back(x);
  endtask

  initial begin
    logic [63:0] rf, rs;
    int          waited;
    m_q = '0; m_sq = 1'b0; m_valid = 1'b0;
    p_rst = 1'b0; p_en = 1'b0; p_sel = 1'b0; p_first = '0; p_second = '0;
    rst = 1'b0; en = 1'b0; select = 1'b0; first = '0; second = '0;

    // Combinational select with reset held, then reset result visible.
    drive(1, 1, 0, 64'hDEADBEEF, 64'h12345678);
    drive(1, 1, 1, 64'hDEADBEEF, 64'h12345678);
    // Data tracking on second, first changes ignored while select=1.
    drive(0, 1, 1, 64'h0, 64'hFFFFFFFF);
    drive(0, 0, 1, 64'h11111111, 64'hFFFFFFFF);
    // Load then hold.
    drive(0, 1, 1, 64'h0, 64'hA5A5A5A5);
    drive(0, 0, 1, 64'h0, 64'h0);
    drive(0, 0, 1, 64'h0, 64'h0);
    // Cache usage: set0 hit, set1-only hit, both miss.
    drive(0, 1, 0, 64'd7, 64'd9);
    drive(0, 1, 1, 64'd7, 64'd9);
    drive(0, 1, 1, 64'd7, 64'd9);
    // Reset mid-stream with en high, then resume loading.
    drive(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    drive(0, 1, 1, 64'hCAFEF00D_0BADC0DE, 64'h0123456789ABCDEF);
    drive(0, 1, 0, 64'hCAFEF00D_0BADC0DE, 64'h0123456789ABCDEF);

    // Randomized traffic across all three widths.
    for (int i = 0; i < 400; i++) begin
      rf = {$urandom, $urandom};
      rs = {$urandom, $urandom};
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, rf, rs);
    end

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
